// File: rtl/note_audio_out.sv
// note_audio_out
//   Turns the per-ear 22-bit note dividers into square-wave tones and shifts
//   them out as 16-bit left-justified stereo samples on the audio DAC pins.
//
// Ports
//   clk             100 MHz system clock
//   rst             synchronous, active-high reset
//   note_div_left   left-ear half-period in clk cycles (0 or 1 = mute)
//   note_div_right  right-ear half-period in clk cycles (0 or 1 = mute)
//   audio_mclk      master clock, clk/4
//   audio_lrck      frame clock, clk/512 (0 = left slot, 1 = right slot)
//   audio_sck       bit clock, clk/16
//   audio_sdin      serial data, MSB first, changes on sck falling edge
module note_audio_out #(
    parameter logic [15:0] AMP = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] note_div_left,
    input  logic [21:0] note_div_right,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam int DATA_W = 16;
    localparam int DIV_W  = 22;

    // Channel 0 is the left ear, channel 1 the right ear.
    logic        [DIV_W-1:0]  note_div [2];
    logic        [DIV_W-1:0]  div_q    [2];
    logic        [DIV_W-1:0]  hcnt     [2];
    logic                     sq       [2];
    logic signed [DATA_W-1:0] sample   [2];

    logic [8:0]  fcnt;
    logic [31:0] frame;

    function automatic logic signed [DATA_W-1:0] tone_sample(
        input logic [DIV_W-1:0] div,
        input logic             phase
    );
        if (div <= DIV_W'(1)) begin
            return '0;
        end else if (phase) begin
            return $signed(AMP);
        end else begin
            return -$signed(AMP);
        end
    endfunction

    assign note_div[0] = note_div_left;
    assign note_div[1] = note_div_right;

    // Tone generators: a new divider always restarts the waveform from the
    // low half-wave, taking priority over a toggle due in the same cycle.
    // The div_q >= 2 guard keeps div_q - 1 from underflowing.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                div_q[ch] <= '0;
                hcnt[ch]  <= '0;
                sq[ch]    <= 1'b0;
            end else if (note_div[ch] != div_q[ch]) begin
                div_q[ch] <= note_div[ch];
                hcnt[ch]  <= '0;
                sq[ch]    <= 1'b0;
            end else if (div_q[ch] <= DIV_W'(1)) begin
                hcnt[ch]  <= '0;
                sq[ch]    <= 1'b0;
            end else if (hcnt[ch] == div_q[ch] - DIV_W'(1)) begin
                hcnt[ch]  <= '0;
                sq[ch]    <= ~sq[ch];
            end else begin
                hcnt[ch]  <= hcnt[ch] + DIV_W'(1);
            end
        end
    end

    assign sample[0] = tone_sample(div_q[0], sq[0]);
    assign sample[1] = tone_sample(div_q[1], sq[1]);

    // Serialiser: the frame is latched from the pre-edge samples on the last
    // count of each frame, so the MSB is on sdin when lrck falls to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            frame <= '0;
        end else begin
            fcnt <= fcnt + 9'd1;
            if (fcnt == 9'd511) begin
                frame <= {sample[0], sample[1]};
            end
        end
    end

    // All pin clocks are plain register bits of the frame counter.
    assign audio_mclk = fcnt[1];
    assign audio_sck  = fcnt[3];
    assign audio_lrck = fcnt[8];
    assign audio_sdin = frame[5'd31 - fcnt[8:4]];

endmodule

// File: tb/tb_note_audio_out.sv
module tb_note_audio_out;

    localparam logic [15:0] AMP1 = 16'h2000;
    localparam logic [15:0] AMP2 = 16'h5A3D;  // -AMP2 == 16'hA5C3

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] ndl = 22'd1;
    logic [21:0] ndr = 22'd1;
    logic        mclk, lrck, sck, sdin;
    logic        mclk2, lrck2, sck2, sdin2;

    always #5 clk = ~clk;

    note_audio_out dut (
        .clk(clk), .rst(rst),
        .note_div_left(ndl), .note_div_right(ndr),
        .audio_mclk(mclk), .audio_lrck(lrck), .audio_sck(sck), .audio_sdin(sdin)
    );

    note_audio_out #(.AMP(AMP2)) dut2 (
        .clk(clk), .rst(rst),
        .note_div_left(ndl), .note_div_right(ndr),
        .audio_mclk(mclk2), .audio_lrck(lrck2), .audio_sck(sck2), .audio_sdin(sdin2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tone phase is derived from the number of cycles since the divider was
    // last loaded: sq = floor(k / div) mod 2. The pin clocks are bits of the
    // elapsed-cycle count since reset.
    logic [21:0] mdiv [2] = '{22'd0, 22'd0};
    longint      mk   [2] = '{0, 0};
    int          mcyc = 0;
    logic [31:0] mframe  = '0;
    logic [31:0] mframe2 = '0;

    function automatic logic msq(input int ch);
        if (mdiv[ch] <= 22'd1) return 1'b0;
        return ((mk[ch] / longint'(mdiv[ch])) % 2) == 1;
    endfunction

    function automatic logic [15:0] msamp(input int ch, input logic [15:0] amp);
        if (mdiv[ch] <= 22'd1) return 16'h0000;
        return msq(ch) ? amp : 16'(17'h10000 - {1'b0, amp});
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mdiv[0] = '0; mdiv[1] = '0;
            mk[0] = 0; mk[1] = 0;
            mcyc = 0; mframe = '0; mframe2 = '0;
        end else begin
            if (mcyc % 512 == 511) begin
                mframe  = {msamp(0, AMP1), msamp(1, AMP1)};
                mframe2 = {msamp(0, AMP2), msamp(1, AMP2)};
            end
            mcyc++;
            if (ndl != mdiv[0]) begin mdiv[0] = ndl; mk[0] = 0; end else mk[0]++;
            if (ndr != mdiv[1]) begin mdiv[1] = ndr; mk[1] = 0; end else mk[1]++;
        end
    end

    // ---------------- compare process ----------------
    bit          chk_en = 1'b0;
    logic        prev_sdin = 1'b0;
    logic [31:0] cap = '0, cap2 = '0;
    logic [31:0] last_frame = '0, last_frame2 = '0;
    bit          seen_e000 = 0, seen_2000 = 0, seen_a5c3 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] fc;
            fc = 9'(mcyc % 512);
            chk("mclk", 32'(mclk), 32'(fc[1]));
            chk("sck",  32'(sck),  32'(fc[3]));
            chk("lrck", 32'(lrck), 32'(fc[8]));
            chk("sdin", 32'(sdin), 32'(mframe[31 - fc[8:4]]));
            chk("sdin2", 32'(sdin2), 32'(mframe2[31 - fc[8:4]]));
            chk("sq_l", 32'(dut.sq[0]), 32'(msq(0)));
            chk("sq_r", 32'(dut.sq[1]), 32'(msq(1)));
            if (fc[3:0] != 4'd0)
                chk("sdin_stable", 32'(sdin), 32'(prev_sdin));
            prev_sdin = sdin;
            if (fc[3:0] == 4'd8) begin
                cap  = {cap[30:0], sdin};
                cap2 = {cap2[30:0], sdin2};
            end
            if (fc == 9'd511) begin
                last_frame  = cap;
                last_frame2 = cap2;
                if (cap == 32'hE000_0000) seen_e000 = 1;
                if (cap == 32'h2000_0000) seen_2000 = 1;
                if (cap2[31:16] == 16'hA5C3) seen_a5c3 = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fc(input int target, input string name);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (mcyc % 512 == target) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    function automatic logic [21:0] pick_div();
        case ($urandom % 4)
            0: return 22'($urandom_range(0, 1));
            1: return 22'($urandom_range(2, 8));
            2: return 22'($urandom_range(9, 200));
            default: return 22'($urandom_range(200, 3000));
        endcase
    endfunction

    initial begin
        // Reset / idle
        rst = 1'b1; ndl = 22'd1; ndr = 22'd1;
        cyc(3);
        chk_en = 1'b1;
        chk("rst_outs", {28'd0, mclk, lrck, sck, sdin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4 * 512);
        chk("idle_frame", last_frame, 32'h0000_0000);
        wait_fc(255, "lrck_edge");
        chk("lrck_255", 32'(lrck), 32'd0);
        @(negedge clk);
        chk("lrck_256", 32'(lrck), 32'd1);

        // Left tone, right muted
        ndl = 22'd1500; ndr = 22'd1;
        cyc(4000);
        chk("left_e000", 32'(seen_e000), 32'd1);
        chk("left_2000", 32'(seen_2000), 32'd1);
        chk("align_a5c3", 32'(seen_a5c3), 32'd1);

        // Divider change mid-half-period
        ndr = 22'd5;
        cyc(3);
        ndr = 22'd7;
        @(negedge clk);
        chk("chg_hcnt0", 32'(dut.hcnt[1]), 32'd0);
        chk("chg_sq0", 32'(dut.sq[1]), 32'd0);
        cyc(6);
        chk("chg_k6", 32'(dut.sq[1]), 32'd0);
        @(negedge clk);
        chk("chg_k7", 32'(dut.sq[1]), 32'd1);
        cyc(6);
        chk("chg_k13", 32'(dut.sq[1]), 32'd1);
        @(negedge clk);
        chk("chg_k14", 32'(dut.sq[1]), 32'd0);

        // Stereo, independent
        ndl = 22'd4; ndr = 22'd6;
        @(negedge clk);
        cyc(3);
        chk("st_l3", 32'(dut.sq[0]), 32'd0);
        @(negedge clk);
        chk("st_l4", 32'(dut.sq[0]), 32'd1);
        cyc(2);
        chk("st_r6", 32'(dut.sq[1]), 32'd1);
        cyc(1100);

        // Randomized segments
        for (int s = 0; s < 16; s++) begin
            ndl = pick_div();
            ndr = pick_div();
            if ($urandom % 8 == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            cyc($urandom_range(50, 900));
        end

        // Reset mid-frame while tones are active
        ndl = 22'd1500; ndr = 22'd6;
        cyc(600);
        wait_fc(300, "rst_mid");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outs", {28'd0, mclk, lrck, sck, sdin}, 32'd0);
        chk("rst_mid_fcnt", 32'(dut.fcnt), 32'd0);
        wait_fc(511, "rst_frame");
        @(negedge clk);
        chk("rst_first_frame", last_frame, 32'h0000_0000);
        wait_fc(511, "rst_frame2");
        @(negedge clk);
        chk("rst_second_frame_nz", 32'(last_frame != 32'd0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
